// File: rtl/dac_daisy_sequencer.sv
// Frame sequencer for the DAC daisy-chain controller: pushes one register-file
// word per chained chip through program/wr_done, then holds update until the DAC side cycles.
module dac_daisy_sequencer #(
  parameter int unsigned N_WORDS = 4,
  parameter int unsigned AW      = 2,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [31:0]   cfg_wdata,
  output logic          cfg_reject,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          clr_err,
  output logic          dc_program,
  output logic [31:0]   dc_din,
  output logic          dc_update,
  input  logic          dc_fifo_full,
  input  logic          dc_wr_done,
  input  logic          dc_state_idle
);

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 16;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_WORDS - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_LO,
    S_WAIT_HI,
    S_UPD_BUSY,
    S_UPD_IDLE,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [DW-1:0]   mem [N_WORDS];
  logic            idle_meta, idle_s;

  logic            prog_d, upd_d, done_d, err_d, busy_d, rej_d;
  logic [DW-1:0]   din_d;
  logic            stall_c;
  logic            cfg_wr_ok_c;

  assign cfg_wr_ok_c = cfg_we && !busy && (32'(cfg_addr) < N_WORDS);

  // dc_state_idle comes from the clk_dac domain
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      idle_meta <= 1'b1;
      idle_s    <= 1'b1;
    end else begin
      idle_meta <= dc_state_idle;
      idle_s    <= idle_meta;
    end
  end

  // frame register file, host-writable only while idle
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < int'(N_WORDS); i++) mem[i] <= '0;
    end else if (cfg_wr_ok_c) begin
      mem[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      tmo_q      <= '0;
      dc_program <= 1'b0;
      dc_update  <= 1'b0;
      dc_din     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cfg_reject <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      dc_program <= prog_d;
      dc_update  <= upd_d;
      dc_din     <= din_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      cfg_reject <= rej_d;
    end
  end

  // next state and next registered outputs; any unmet wait condition counts toward timeout
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = '0;
    prog_d  = 1'b0;
    upd_d   = dc_update;
    din_d   = dc_din;
    done_d  = 1'b0;
    err_d   = clr_err ? 1'b0 : err;
    rej_d   = cfg_we && busy;
    stall_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!dc_fifo_full) begin
          prog_d  = 1'b1;
          din_d   = mem[idx_q];
          state_d = S_WAIT_LO;
        end else begin
          stall_c = 1'b1;
        end
      end
      S_WAIT_LO: begin
        // a high wr_done here is left over from the previous word
        if (!dc_wr_done) state_d = S_WAIT_HI;
        else             stall_c = 1'b1;
      end
      S_WAIT_HI: begin
        if (dc_wr_done) begin
          if (idx_q == LAST_IDX) begin
            upd_d   = 1'b1;
            state_d = S_UPD_BUSY;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_LOAD;
          end
        end else begin
          stall_c = 1'b1;
        end
      end
      S_UPD_BUSY: begin
        if (!idle_s) state_d = S_UPD_IDLE;
        else         stall_c = 1'b1;
      end
      S_UPD_IDLE: begin
        if (idle_s) begin
          upd_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      S_ERR: begin
        err_d   = 1'b1;
        prog_d  = 1'b0;
        upd_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (stall_c) begin
      if (tmo_q == TMO_MAX) begin
        state_d = S_ERR;
        prog_d  = 1'b0;
        upd_d   = 1'b0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_dac_daisy_sequencer.sv
// Scoreboard bench for dac_daisy_sequencer with a behavioural daisy-chain controller model.
module tb_dac_daisy_sequencer;

  localparam int unsigned NW  = 4;
  localparam int unsigned AW  = 2;
  localparam int unsigned TMO = 300;

  logic          clk;
  logic          rst_b;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [31:0]   cfg_wdata;
  logic          cfg_reject;
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic          clr_err;
  logic          dc_program;
  logic [31:0]   dc_din;
  logic          dc_update;
  logic          dc_fifo_full;
  logic          dc_wr_done;
  logic          dc_state_idle;

  dac_daisy_sequencer #(.N_WORDS(NW), .AW(AW), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_reject   (cfg_reject),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .clr_err      (clr_err),
    .dc_program   (dc_program),
    .dc_din       (dc_din),
    .dc_update    (dc_update),
    .dc_fifo_full (dc_fifo_full),
    .dc_wr_done   (dc_wr_done),
    .dc_state_idle(dc_state_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // controller model: wr_done drops on program and returns 3 cycles later;
  // DAC side goes non-idle 40 cycles after a frame's first word and returns once update is seen
  logic wr_done_m, dac_idle_m;
  int   wr_cnt, sh, sh_cnt;
  bit   idle_stuck;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_done_m  <= 1'b0;
      wr_cnt     <= 0;
      dac_idle_m <= 1'b1;
      sh         <= 0;
      sh_cnt     <= 0;
    end else begin
      if (dc_program) begin
        wr_done_m <= 1'b0;
        wr_cnt    <= 3;
      end else if (wr_cnt > 0) begin
        wr_cnt <= wr_cnt - 1;
        if (wr_cnt == 1) wr_done_m <= 1'b1;
      end
      case (sh)
        0: if (dc_program && !idle_stuck) begin sh <= 1; sh_cnt <= 40; end
        1: if (sh_cnt > 1) sh_cnt <= sh_cnt - 1;
           else begin dac_idle_m <= 1'b0; sh <= 2; sh_cnt <= 20; end
        2: if (sh_cnt > 0) sh_cnt <= sh_cnt - 1;
           else if (dc_update) begin dac_idle_m <= 1'b1; sh <= 3; end
        default: if (!dc_update) sh <= 0;
      endcase
    end
  end

  assign dc_wr_done    = wr_done_m;
  assign dc_state_idle = dac_idle_m;

  // scoreboard: expected words are queued at start, popped on each program pulse
  logic [31:0] exp_q[$];
  logic [31:0] shadow[NW];
  int prog_cnt = 0, done_cnt = 0, rej_cnt = 0, upd_cyc = 0;

  always @(negedge clk) begin
    if (rst_b) begin
      if (dc_program) begin
        prog_cnt++;
        check("prog_upd_overlap", 32'(dc_update), 0);
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else                   check("din", dc_din, exp_q.pop_front());
      end
      if (done)       done_cnt++;
      if (cfg_reject) rej_cnt++;
      if (dc_update)  upd_cyc++;
    end
  end

  task automatic cfg_write(input int addr, input logic [31:0] data, input bit accept);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(addr);
    cfg_wdata = data;
    @(negedge clk);
    cfg_we = 1'b0;
    if (accept) shadow[addr] = data;
  endtask

  task automatic push_frame();
    for (int i = 0; i < int'(NW); i++) exp_q.push_back(shadow[i]);
  endtask

  task automatic start_frame(input bit chk_lat);
    push_frame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (chk_lat) begin
      check("busy_after_start", 32'(busy), 1);
      @(negedge clk);
      check("prog_latency", 32'(dc_program), 1);
    end
  endtask

  task automatic wait_end(input string tag, input int bound);
    bit fin = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done || err) begin fin = 1'b1; break; end
    end
    check({tag, "_end"}, 32'(fin), 1);
    @(negedge clk);
  endtask

  task automatic wait_prog(input string tag, input int target);
    bit fin = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (prog_cnt >= target) begin fin = 1'b1; break; end
    end
    check({tag, "_prog_wait"}, 32'(fin), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int p0, d0, r0;
    bit fin;
    rst_b = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b0; clr_err = 1'b0; dc_fifo_full = 1'b0; idle_stuck = 1'b0;
    for (int i = 0; i < int'(NW); i++) shadow[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_program", 32'(dc_program), 0);
    check("rst_update", 32'(dc_update), 0);
    check("rst_din", dc_din, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_reject", 32'(cfg_reject), 0);
    rst_b = 1'b1;

    // basic four-word frame
    for (int i = 0; i < int'(NW); i++) cfg_write(i, 32'hA5A5_0001 + 32'(i), 1'b1);
    p0 = prog_cnt; d0 = done_cnt;
    start_frame(1'b1);
    wait_end("t1", 500);
    check("t1_done", 32'(done_cnt - d0), 1);
    check("t1_progs", 32'(prog_cnt - p0), 4);
    check("t1_err", 32'(err), 0);
    check("t1_busy", 32'(busy), 0);
    check("t1_update", 32'(dc_update), 0);
    check("t1_sb", exp_q.size(), 0);

    // FIFO full stall at word 2
    p0 = prog_cnt; d0 = done_cnt;
    start_frame(1'b0);
    wait_prog("t2", p0 + 2);
    dc_fifo_full = 1'b1;
    r0 = prog_cnt;
    repeat (20) @(negedge clk);
    check("t2_full_no_prog", 32'(prog_cnt - r0), 0);
    dc_fifo_full = 1'b0;
    wait_end("t2", 500);
    check("t2_done", 32'(done_cnt - d0), 1);
    check("t2_progs", 32'(prog_cnt - p0), 4);
    check("t2_err", 32'(err), 0);
    check("t2_sb", exp_q.size(), 0);

    // write while busy is rejected and leaves the old word
    r0 = rej_cnt; d0 = done_cnt;
    start_frame(1'b0);
    repeat (3) @(negedge clk);
    cfg_write(1, 32'hDEAD_BEEF, 1'b0);
    wait_end("t3a", 500);
    check("t3_reject", 32'(rej_cnt - r0), 1);
    start_frame(1'b0);
    wait_end("t3b", 500);
    check("t3_done", 32'(done_cnt - d0), 2);
    check("t3_sb", exp_q.size(), 0);

    // start during UPD_IDLE is ignored
    p0 = prog_cnt; d0 = done_cnt;
    start_frame(1'b0);
    fin = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sh == 2 && dc_update) begin fin = 1'b1; break; end
    end
    check("t4_reach_upd", 32'(fin), 1);
    repeat (4) @(negedge clk);
    check("t4_update_held", 32'(dc_update), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("t4", 500);
    repeat (40) @(negedge clk);
    check("t4_done_once", 32'(done_cnt - d0), 1);
    check("t4_progs", 32'(prog_cnt - p0), 4);
    check("t4_busy", 32'(busy), 0);

    // write and start in the same idle cycle: new data is sent
    d0 = done_cnt;
    shadow[0] = 32'h1234_5678;
    push_frame();
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = 32'h1234_5678; start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    wait_end("t5", 500);
    check("t5_done", 32'(done_cnt - d0), 1);
    check("t5_sb", exp_q.size(), 0);

    // DAC never goes busy: timeout from UPD_BUSY
    idle_stuck = 1'b1;
    d0 = done_cnt;
    upd_cyc = 0;
    start_frame(1'b0);
    wait_end("t6", int'(TMO) + 400);
    check("t6_err", 32'(err), 1);
    check("t6_update", 32'(dc_update), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_no_done", 32'(done_cnt - d0), 0);
    check("t6_upd_cycles", 32'(upd_cyc), 32'(TMO + 1));
    check("t6_sb", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check("t6_err_sticky", 32'(err), 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("t6_err_clr", 32'(err), 0);
    idle_stuck = 1'b0;

    // reset during WAIT_HI of word 1
    p0 = prog_cnt;
    start_frame(1'b0);
    wait_prog("t7", p0 + 2);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("t7_program", 32'(dc_program), 0);
    check("t7_update", 32'(dc_update), 0);
    check("t7_busy", 32'(busy), 0);
    check("t7_din", dc_din, 0);
    exp_q.delete();
    for (int i = 0; i < int'(NW); i++) shadow[i] = '0;
    @(negedge clk);
    rst_b = 1'b1;
    p0 = prog_cnt; d0 = done_cnt;
    start_frame(1'b0);
    wait_end("t7", 500);
    check("t7_done", 32'(done_cnt - d0), 1);
    check("t7_progs", 32'(prog_cnt - p0), 4);
    check("t7_sb", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
